hex_entry_ctrl: RTL and testbench

Board-level debug writer that builds a 32-bit word from the slide switches one hex nibble at a time, under control of debounced push-buttons. It presents the finished word to the processor's debug write port through a valid/ready handshake, with an auto-incrementing word address. The word being entered is also exported so the existing seven-segment display path can show it while it is typed.

---
 rtl/debug_io_pkg.sv | 23 ++
 rtl/key_debounce.sv | 61 ++++++
 rtl/hex_entry_ctrl.sv | 118 +++++++++++
 tb/tb_hex_entry_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_io_pkg.sv
// Shared types and constants for the board-level hex debug writer.
// Holds the entry FSM encoding, word geometry and the default debounce length.
package debug_io_pkg;

    typedef enum logic {
        ENTER = 1'b0,
        SEND  = 1'b1
    } entry_state_t;

    localparam int NIB_W                   = 4;
    localparam int WORD_W                  = 32;
    localparam int NIBBLES_PER_WORD        = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // New digit enters at the bottom; the oldest nibble falls off the top.
    function automatic logic [WORD_W-1:0] shift_in_nibble(
        input logic [WORD_W-1:0] word,
        input logic [NIB_W-1:0]  nib
    );
        return {word[WORD_W-NIB_W-1:0], nib};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Conditions one raw active-low push-button: 2-FF synchronizer, stable-count
// debouncer, and a single-cycle pulse on each debounced press (high-to-low).
module key_debounce
    import debug_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic w_differs;
    logic w_flip;

    assign w_differs = (r_sync2 != r_level);
    assign w_flip    = w_differs && (r_cnt == CNT_LAST);

    // Synchronizer idles released so reset never fakes a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where the synchronized level matches the accepted one restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= w_flip && r_level;
            if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/hex_entry_ctrl.sv
// Builds a 32-bit word from switch nibbles under push-button control and hands it
// to the debug write port. Handshake: a write transfers on any edge where wr_valid
// and wr_ready are both high; wr_valid, wr_addr and wr_data hold until then.
module hex_entry_ctrl
    import debug_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ADDR_W          = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIB_W-1:0]  sw_nibble,
    input  logic              key_shift_n,
    input  logic              key_commit_n,
    input  logic              key_clear_n,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] entry_word,
    output logic [3:0]        nib_count,
    output logic              busy
);

    logic w_shift_p;
    logic w_commit_p;
    logic w_clear_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_shift_n),
        .press (w_shift_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_commit (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_commit_n),
        .press (w_commit_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_clear_n),
        .press (w_clear_p)
    );

    entry_state_t      r_state;
    entry_state_t      w_state_nxt;
    logic [WORD_W-1:0] r_entry;
    logic [WORD_W-1:0] w_entry_nxt;
    logic [WORD_W-1:0] r_wr_data;
    logic [WORD_W-1:0] w_wr_data_nxt;
    logic [3:0]        r_nib;
    logic [3:0]        w_nib_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_entry_nxt   = r_entry;
        w_wr_data_nxt = r_wr_data;
        w_nib_nxt     = r_nib;
        w_addr_nxt    = r_addr;
        case (r_state)
            ENTER: begin
                if (w_clear_p) begin
                    w_entry_nxt = '0;
                    w_nib_nxt   = '0;
                end else if (w_commit_p) begin
                    w_wr_data_nxt = r_entry;
                    w_state_nxt   = SEND;
                end else if (w_shift_p) begin
                    w_entry_nxt = shift_in_nibble(r_entry, sw_nibble);
                    if (r_nib < 4'(NIBBLES_PER_WORD)) begin
                        w_nib_nxt = r_nib + 4'd1;
                    end
                end
            end
            SEND: begin
                // Key pulses are ignored here; only the handshake moves us on.
                if (wr_ready) begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_entry_nxt = '0;
                    w_nib_nxt   = '0;
                    w_state_nxt = ENTER;
                end
            end
            default: w_state_nxt = ENTER;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ENTER;
            r_entry   <= '0;
            r_wr_data <= '0;
            r_nib     <= '0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_entry   <= w_entry_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_nib     <= w_nib_nxt;
            r_addr    <= w_addr_nxt;
        end
    end

    assign wr_valid   = (r_state == SEND);
    assign busy       = (r_state == SEND);
    assign wr_addr    = r_addr;
    assign wr_data    = r_wr_data;
    assign entry_word = r_entry;
    assign nib_count  = r_nib;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Directed bench for hex_entry_ctrl with a short debounce: nibble entry, overflow,
// bounce rejection, held write under back-pressure, address wrap and reset mid-write.
module tb_hex_entry_ctrl;

    localparam int D        = 4;
    localparam int AW       = 6;
    localparam int HOLD     = D + 6;
    localparam int K_SHIFT  = 0;
    localparam int K_COMMIT = 1;
    localparam int K_CLEAR  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    sw_nibble = 4'h0;
    logic          key_shift_n = 1'b1;
    logic          key_commit_n = 1'b1;
    logic          key_clear_n = 1'b1;
    logic          wr_ready = 1'b0;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   entry_word;
    logic [3:0]    nib_count;
    logic          busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Stability monitor used while a write is held off by wr_ready=0.
    logic          mon_en = 1'b0;
    int            mon_bad = 0;
    int            mon_cycles = 0;
    logic [AW-1:0] mon_addr;
    logic [31:0]   mon_data;
    logic [31:0]   mon_entry;
    logic [3:0]    mon_nib;

    always #5 clk = ~clk;

    hex_entry_ctrl #(.DEBOUNCE_CYCLES(D), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_nibble    (sw_nibble),
        .key_shift_n  (key_shift_n),
        .key_commit_n (key_commit_n),
        .key_clear_n  (key_clear_n),
        .wr_ready     (wr_ready),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .entry_word   (entry_word),
        .nib_count    (nib_count),
        .busy         (busy)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            mon_cycles++;
            if (wr_valid !== 1'b1 || busy !== 1'b1 || wr_addr !== mon_addr ||
                wr_data !== mon_data || entry_word !== mon_entry || nib_count !== mon_nib)
                mon_bad++;
        end
    end

    task automatic set_key(input int k, input logic v);
        case (k)
            K_SHIFT:  key_shift_n  = v;
            K_COMMIT: key_commit_n = v;
            default:  key_clear_n  = v;
        endcase
    endtask

    task automatic press(input int k);
        @(negedge clk);
        set_key(k, 1'b0);
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        set_key(k, 1'b1);
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic shift_nib(input logic [3:0] v);
        sw_nibble = v;
        press(K_SHIFT);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presses commit and records every cycle wr_valid is seen high (index = edges after first low sample).
    task automatic do_commit(output int vcnt, output int vidx, output logic [AW-1:0] a,
                             output logic [31:0] d);
        vcnt = 0;
        vidx = -1;
        a = '0;
        d = '0;
        @(negedge clk);
        key_commit_n = 1'b0;
        for (int i = 0; i < 2 * HOLD; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr_valid === 1'b1) begin
                vcnt++;
                if (vidx < 0) vidx = i;
                a = wr_addr;
                d = wr_data;
            end
            if (i == HOLD - 1) key_commit_n = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({wr_valid, busy} !== 2'b00) $display("FAIL reset_valid_busy: got %b expected 00", {wr_valid, busy});
        else pass_cnt++;
        total_cnt++;
        if (wr_addr !== '0) $display("FAIL reset_addr: got %0d expected 0", wr_addr);
        else pass_cnt++;
        total_cnt++;
        if (wr_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", wr_data);
        else pass_cnt++;
        total_cnt++;
        if (entry_word !== 32'h0 || nib_count !== 4'd0)
            $display("FAIL reset_entry: got %h/%0d expected 00000000/0", entry_word, nib_count);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_shift_commit();
        int vcnt, vidx;
        logic [AW-1:0] a;
        logic [31:0] d;
        wr_ready = 1'b1;
        for (int i = 1; i <= 8; i++) shift_nib(4'(i));
        total_cnt++;
        if (entry_word !== 32'h12345678 || nib_count !== 4'd8)
            $display("FAIL entry_8_nibbles: got %h/%0d expected 12345678/8", entry_word, nib_count);
        else pass_cnt++;
        do_commit(vcnt, vidx, a, d);
        total_cnt++;
        if (vcnt !== 1) $display("FAIL single_valid_cycle: got %0d cycles expected 1", vcnt);
        else pass_cnt++;
        total_cnt++;
        if (vidx !== D + 2) $display("FAIL commit_latency: got %0d expected %0d", vidx, D + 2);
        else pass_cnt++;
        total_cnt++;
        if (a !== 6'd0 || d !== 32'h12345678)
            $display("FAIL first_write: got addr %0d data %h expected 0 12345678", a, d);
        else pass_cnt++;
        total_cnt++;
        if (entry_word !== 32'h0 || nib_count !== 4'd0)
            $display("FAIL clear_after_xfer: got %h/%0d expected 00000000/0", entry_word, nib_count);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        shift_nib(4'hF);
        press(K_CLEAR);
        total_cnt++;
        if (entry_word !== 32'h0 || nib_count !== 4'd0)
            $display("FAIL clear_key: got %h/%0d expected 00000000/0", entry_word, nib_count);
        else pass_cnt++;
        shift_nib(4'hA);
        total_cnt++;
        if (entry_word !== 32'h0000000A || nib_count !== 4'd1)
            $display("FAIL first_nibble: got %h/%0d expected 0000000a/1", entry_word, nib_count);
        else pass_cnt++;
        for (int i = 1; i <= 8; i++) shift_nib(4'(i));
        total_cnt++;
        if (entry_word !== 32'h12345678 || nib_count !== 4'd8)
            $display("FAIL overflow_drop: got %h/%0d expected 12345678/8", entry_word, nib_count);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic [3:0] early, on_time;
        early = 4'hF;
        on_time = 4'hF;
        press(K_CLEAR);
        sw_nibble = 4'h5;
        @(negedge clk);
        key_shift_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        key_shift_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_shift_n = 1'b0;
        for (int j = 0; j < HOLD; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == D + 1) early = nib_count;
            if (j == D + 2) on_time = nib_count;
        end
        key_shift_n = 1'b1;
        repeat (HOLD + 2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (early !== 4'd0) $display("FAIL bounce_early: got %0d expected 0", early);
        else pass_cnt++;
        total_cnt++;
        if (on_time !== 4'd1) $display("FAIL bounce_latency: got %0d expected 1", on_time);
        else pass_cnt++;
        total_cnt++;
        if (nib_count !== 4'd1 || entry_word !== 32'h5)
            $display("FAIL bounce_single_pulse: got %h/%0d expected 00000005/1", entry_word, nib_count);
        else pass_cnt++;
    endtask

    task automatic test_ready_low();
        press(K_CLEAR);
        wr_ready = 1'b0;
        shift_nib(4'h9);
        shift_nib(4'hC);
        press(K_COMMIT);
        total_cnt++;
        if (wr_valid !== 1'b1 || wr_addr !== 6'd1 || wr_data !== 32'h9C)
            $display("FAIL held_request: got v%b addr %0d data %h expected v1 1 0000009c",
                     wr_valid, wr_addr, wr_data);
        else pass_cnt++;
        mon_addr = 6'd1;
        mon_data = 32'h9C;
        mon_entry = 32'h9C;
        mon_nib = 4'd2;
        mon_bad = 0;
        mon_cycles = 0;
        mon_en = 1'b1;
        shift_nib(4'h3);
        press(K_CLEAR);
        mon_en = 1'b0;
        total_cnt++;
        if (mon_bad !== 0) $display("FAIL send_stability: got %0d unstable cycles expected 0", mon_bad);
        else pass_cnt++;
        total_cnt++;
        if (mon_cycles < 5) $display("FAIL send_hold_length: got %0d cycles expected >= 5", mon_cycles);
        else pass_cnt++;
        wr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (wr_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL xfer_on_first_ready: got v%b busy%b expected v0 busy0", wr_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (wr_addr !== 6'd2 || entry_word !== 32'h0 || nib_count !== 4'd0)
            $display("FAIL after_held_xfer: got addr %0d %h/%0d expected 2 00000000/0",
                     wr_addr, entry_word, nib_count);
        else pass_cnt++;
    endtask

    task automatic test_addr_wrap();
        int vcnt, vidx;
        logic [AW-1:0] a;
        logic [31:0] d;
        apply_reset();
        wr_ready = 1'b1;
        for (int i = 0; i < 65; i++) begin
            do_commit(vcnt, vidx, a, d);
            total_cnt++;
            if (vcnt !== 1 || a !== AW'(i % 64) || d !== 32'h0)
                $display("FAIL wrap_commit_%0d: got %0d cycles addr %0d data %h expected 1 %0d 00000000",
                         i, vcnt, a, d, i % 64);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_send();
        int vcnt, vidx;
        logic [AW-1:0] a;
        logic [31:0] d;
        wr_ready = 1'b0;
        shift_nib(4'h7);
        press(K_COMMIT);
        total_cnt++;
        if (wr_valid !== 1'b1 || wr_addr !== 6'd1 || wr_data !== 32'h7)
            $display("FAIL pre_reset_send: got v%b addr %0d data %h expected v1 1 00000007",
                     wr_valid, wr_addr, wr_data);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({wr_valid, busy, wr_addr, nib_count} !== '0 || wr_data !== 32'h0 || entry_word !== 32'h0)
            $display("FAIL reset_mid_send: got v%b b%b addr %0d data %h entry %h nib %0d expected all 0",
                     wr_valid, busy, wr_addr, wr_data, entry_word, nib_count);
        else pass_cnt++;
        wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (wr_valid !== 1'b0 || wr_addr !== 6'd0)
            $display("FAIL reset_no_xfer: got v%b addr %0d expected v0 0", wr_valid, wr_addr);
        else pass_cnt++;
        rst_n = 1'b1;
        do_commit(vcnt, vidx, a, d);
        total_cnt++;
        if (vcnt !== 1 || a !== 6'd0 || d !== 32'h0)
            $display("FAIL post_reset_commit: got %0d cycles addr %0d data %h expected 1 0 00000000",
                     vcnt, a, d);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_shift_commit();
        test_overflow();
        test_bounce();
        test_ready_low();
        test_addr_wrap();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
